// File: rtl/label_compactor_pkg.sv
// Shared sizing and FSM encoding for the label compactor and its lookup table.
package label_compactor_pkg;

  localparam int MAX_OBJ = 15;
  localparam int IMG_PIX = 1024;
  localparam int ADDR_W  = 10;
  localparam int LBL_W   = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CMP,
    WR,
    DONE
  } state_e;

endpackage

// File: rtl/label_compactor_cam.sv
// Old-label lookup table: combinational match on key, allocation at a caller-chosen entry.
module label_cam #(
  parameter int N  = 15,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          alloc,
  input  logic [IW-1:0] alloc_idx,
  input  logic [7:0]    key,
  output logic          hit,
  output logic [IW-1:0] idx
);

  logic [N-1:0] vld_q;
  logic [7:0]   lbl_q [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < N; i++) lbl_q[i] <= '0;
    end else if (clear) begin
      vld_q <= '0;
    end else if (alloc) begin
      vld_q[alloc_idx] <= 1'b1;
      lbl_q[alloc_idx] <= key;
    end
  end

  // Stored labels are unique, so at most one entry can match.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vld_q[i] && (lbl_q[i] == key)) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/label_compactor.sv
// Rewrites a label image in place so nonzero labels become 1..obj_cnt in raster order of first appearance.
// Optional per-label pixel counters and area readout are enabled with LABEL_COMPACTOR_AREA_EN.
module label_compactor #(
  parameter int MAX_OBJ = label_compactor_pkg::MAX_OBJ,
  parameter int IMG_PIX = label_compactor_pkg::IMG_PIX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  sram_q,
  output logic [9:0]  sram_a,
  output logic [7:0]  sram_d,
  output logic        sram_wen,
  output logic        done,
  output logic [3:0]  obj_cnt,
  output logic        overflow
`ifdef LABEL_COMPACTOR_AREA_EN
  ,
  input  logic [3:0]  area_sel,
  output logic [10:0] area
`endif
);

  import label_compactor_pkg::*;

  localparam int                IW        = $clog2(MAX_OBJ);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_OBJ);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIX - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, addr_d, sram_a_q;
  logic [LBL_W-1:0]  sram_d_q, label_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              wen_q, done_q, ovf_q;
  logic              start_ok, cam_hit, cam_alloc, full_miss, need_wr, last_pix;
  logic [IW-1:0]     cam_idx;

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign addr_d   = addr_q + 1'b1;
  assign last_pix = (addr_q == LAST_ADDR);

  label_cam #(.N(MAX_OBJ), .IW(IW)) u_cam (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .alloc     (cam_alloc),
    .alloc_idx (IW'(cnt_q)),
    .key       (sram_q),
    .hit       (cam_hit),
    .idx       (cam_idx)
  );

  // New label for the pixel under CMP; defaults to the old one (zero or overflowed).
  always_comb begin
    cam_alloc = 1'b0;
    full_miss = 1'b0;
    label_d   = sram_q;
    if ((state_q == CMP) && (sram_q != '0)) begin
      if (cam_hit) begin
        label_d = LBL_W'(cam_idx) + 8'd1;
      end else if (cnt_q < MAX_CNT) begin
        cam_alloc = 1'b1;
        label_d   = LBL_W'(cnt_q) + 8'd1;
      end else begin
        full_miss = 1'b1;
      end
    end
  end

  assign need_wr = (state_q == CMP) && (label_d != sram_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      sram_a_q <= '0;
      sram_d_q <= '0;
      wen_q    <= 1'b1;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            state_q  <= RD;
            addr_q   <= '0;
            sram_a_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
          end
        end
        RD: state_q <= CMP;
        CMP: begin
          if (cam_alloc) cnt_q <= cnt_q + 1'b1;
          if (full_miss) ovf_q <= 1'b1;
          if (need_wr) begin
            state_q  <= WR;
            sram_d_q <= label_d;
            wen_q    <= 1'b0;
          end else if (last_pix) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q  <= RD;
            addr_q   <= addr_d;
            sram_a_q <= addr_d;
          end
        end
        WR: begin
          wen_q <= 1'b1;
          if (last_pix) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q  <= RD;
            addr_q   <= addr_d;
            sram_a_q <= addr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_a   = sram_a_q;
  assign sram_d   = sram_d_q;
  assign sram_wen = wen_q;
  assign done     = done_q;
  assign obj_cnt  = cnt_q;
  assign overflow = ovf_q;

`ifdef LABEL_COMPACTOR_AREA_EN
  logic [10:0]   area_q [MAX_OBJ];
  logic [IW-1:0] area_idx;

  assign area_idx = cam_hit ? cam_idx : IW'(cnt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_OBJ; i++) area_q[i] <= '0;
    end else if (start_ok) begin
      for (int i = 0; i < MAX_OBJ; i++) area_q[i] <= '0;
    end else if ((state_q == CMP) && (cam_hit || cam_alloc)) begin
      area_q[area_idx] <= area_q[area_idx] + 11'd1;
    end
  end

  always_comb begin
    area = '0;
    if ((area_sel != 4'd0) && (area_sel <= cnt_q)) area = area_q[IW'(area_sel - 4'd1)];
  end
`endif

endmodule

// File: tb/tb_label_compactor.sv
// Randomized bench for label_compactor against a queue-based compaction model.
module tb_label_compactor;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  sram_q, sram_d;
  logic [9:0]  sram_a;
  logic        sram_wen, done, overflow;
  logic [3:0]  obj_cnt;
`ifdef LABEL_COMPACTOR_AREA_EN
  logic [3:0]  area_sel;
  logic [10:0] area;
`endif

  logic [7:0] mem     [1024];
  logic [7:0] exp_mem [1024];
  int         exp_area [16];
  int         exp_cnt, exp_wr, exp_ovf;
  int         wr_cnt = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  label_compactor dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sram_q   (sram_q),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_wen (sram_wen),
    .done     (done),
    .obj_cnt  (obj_cnt),
    .overflow (overflow)
`ifdef LABEL_COMPACTOR_AREA_EN
    ,
    .area_sel (area_sel),
    .area     (area)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: read data one cycle after the address, active-low write.
  always @(posedge clk) begin
    if (!sram_wen) begin
      mem[sram_a] = sram_d;
      wr_cnt++;
    end
    sram_q <= mem[sram_a];
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Relabel by first appearance; labels beyond the table size stay as they are.
  task automatic ref_compact();
    logic [7:0] seen[$];
    int k;
    exp_wr  = 0;
    exp_ovf = 0;
    for (int s = 0; s < 16; s++) exp_area[s] = 0;
    for (int p = 0; p < 1024; p++) begin
      exp_mem[p] = mem[p];
      if (mem[p] != 8'd0) begin
        k = -1;
        foreach (seen[j]) if (seen[j] == mem[p]) k = j;
        if (k < 0 && seen.size() < 15) begin
          seen.push_back(mem[p]);
          k = seen.size() - 1;
        end else if (k < 0) begin
          exp_ovf = 1;
        end
        if (k >= 0) begin
          exp_area[k+1]++;
          if (int'(mem[p]) != k + 1) begin
            exp_mem[p] = 8'(k + 1);
            exp_wr++;
          end
        end
      end
    end
    exp_cnt = seen.size();
  endtask

  task automatic run_scan(input bit poke, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("scan_addr0", int'(sram_a), 0);
    check("scan_done_clr", int'(done), 0);
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk);
      cyc++;
      #1;
      start = poke && (cyc == 101);
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic scan_and_verify(input string tag, input bit poke);
    int cyc, w0, bad;
    ref_compact();
    w0 = wr_cnt;
    run_scan(poke, cyc);
    check({tag, "_cycles"}, cyc, 2048 + exp_wr);
    check({tag, "_writes"}, wr_cnt - w0, exp_wr);
    check({tag, "_obj_cnt"}, int'(obj_cnt), exp_cnt);
    check({tag, "_overflow"}, int'(overflow), exp_ovf);
    bad = 0;
    for (int p = 0; p < 1024; p++) if (mem[p] !== exp_mem[p]) bad++;
    check({tag, "_image_bad_pixels"}, bad, 0);
`ifdef LABEL_COMPACTOR_AREA_EN
    bad = 0;
    for (int s = 0; s < 16; s++) begin
      area_sel = 4'(s);
      #1;
      if (int'(area) != ((s <= exp_cnt) ? exp_area[s] : 0)) bad++;
    end
    area_sel = 4'd0;
    check({tag, "_area_bad_sel"}, bad, 0);
`endif
  endtask

  task automatic fill_random(input int lim, input int zero_pct);
    for (int p = 0; p < 1024; p++)
      mem[p] = ($urandom_range(99, 0) < zero_pct) ? 8'd0 : 8'($urandom_range(lim, 1));
  endtask

  task automatic clear_mem();
    for (int p = 0; p < 1024; p++) mem[p] = 8'd0;
  endtask

  initial begin
    int wc, n;
    reset = 1'b1;
    start = 1'b0;
`ifdef LABEL_COMPACTOR_AREA_EN
    area_sel = 4'd0;
`endif
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sram_a", int'(sram_a), 0);
    check("rst_sram_d", int'(sram_d), 0);
    check("rst_sram_wen", int'(sram_wen), 1);
    check("rst_done", int'(done), 0);
    check("rst_obj_cnt", int'(obj_cnt), 0);
    check("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    reset = 1'b0;

    scan_and_verify("zero", 1'b0);

    clear_mem();
    for (int p = 0; p < 4; p++) mem[p] = 8'h37;
    mem[1023] = 8'h12;
    wc = wr_cnt;
    scan_and_verify("two_obj", 1'b0);
    check("two_obj_pix3", int'(mem[3]), 1);
    check("two_obj_pix3ff", int'(mem[1023]), 2);
    check("two_obj_total_writes", wr_cnt - wc, 5);
`ifdef LABEL_COMPACTOR_AREA_EN
    area_sel = 4'd1; #1; check("area_sel1", int'(area), 4);
    area_sel = 4'd2; #1; check("area_sel2", int'(area), 1);
    area_sel = 4'd3; #1; check("area_sel3", int'(area), 0);
    area_sel = 4'd0;
`endif

    wc = wr_cnt;
    scan_and_verify("rescan", 1'b0);
    check("rescan_no_writes", wr_cnt - wc, 0);
    check("rescan_obj_cnt", int'(obj_cnt), 2);

    clear_mem();
    for (int p = 0; p < 16; p++) mem[p] = 8'(8'h10 + p);
    scan_and_verify("sixteen", 1'b0);
    n = 0;
    for (int p = 0; p < 15; p++) if (int'(mem[p]) != p + 1) n++;
    check("sixteen_remap_bad", n, 0);
    check("sixteen_pix15", int'(mem[15]), 'h1F);
    check("sixteen_overflow", int'(overflow), 1);
    check("sixteen_obj_cnt", int'(obj_cnt), 15);

    fill_random(4, 50);
    scan_and_verify("rand_small", 1'b1);
    fill_random(12, 70);
    scan_and_verify("rand_mid", 1'b0);
    fill_random(30, 60);
    scan_and_verify("rand_over", 1'b1);
    fill_random(255, 90);
    scan_and_verify("rand_sparse", 1'b0);

    // Abort a scan at pixel 0x200, then restart from the partially remapped image.
    fill_random(20, 40);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (sram_a != 10'h200 && n < 5000) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("midrst_reach_200", int'(sram_a), 'h200);
    reset = 1'b1;
    wc = wr_cnt;
    #1;
    check("midrst_sram_a", int'(sram_a), 0);
    check("midrst_sram_d", int'(sram_d), 0);
    check("midrst_wen", int'(sram_wen), 1);
    check("midrst_done", int'(done), 0);
    check("midrst_obj_cnt", int'(obj_cnt), 0);
    check("midrst_overflow", int'(overflow), 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_write", wr_cnt - wc, 0);
    reset = 1'b0;
    scan_and_verify("after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/label_compactor.md
LABEL_COMPACTOR -- requirements
Module: label_compactor

Interface
REQ-001 The module SHALL have parameter MAX_OBJ, default 15, giving the maximum number of distinct nonzero labels remapped.
REQ-002 The module SHALL have parameter IMG_PIX, default 1024, giving the number of label-memory words scanned, at addresses 0..IMG_PIX-1.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: begins a scan when sampled high in IDLE or DONE; it is driven by the labeling engine's finish.
REQ-006 The module SHALL have port sram_q, input, 8 bits: synchronous SRAM read data, valid one cycle after the address is presented.
REQ-007 The module SHALL have port sram_a, output, 10 bits: the SRAM address.
REQ-008 The module SHALL have port sram_d, output, 8 bits: the SRAM write data.
REQ-009 The module SHALL have port sram_wen, output, 1 bit: SRAM write enable, active low.
REQ-010 The module SHALL have port done, output, 1 bit: high from scan completion until the next accepted start.
REQ-011 The module SHALL have port obj_cnt, output, 4 bits: the number of distinct nonzero labels found.
REQ-012 The module SHALL have port overflow, output, 1 bit: sticky; set when more than MAX_OBJ distinct labels are seen.

Function
REQ-013 The FSM SHALL have states IDLE, RD, CMP, WR, DONE, with transitions: IDLE/DONE -(start)-> RD -> CMP -> WR or RD or DONE; WR -> RD or DONE.
REQ-014 In RD, the block SHALL drive sram_a=addr and sram_wen=1.
REQ-015 In CMP, sram_q is the label at addr; a zero label SHALL be left unchanged.
REQ-016 In CMP, a nonzero label SHALL be looked up combinationally in a MAX_OBJ-entry table of {valid, old_label}; the hit index i gives new label i+1.
REQ-017 On a lookup miss with obj_cnt<MAX_OBJ, entry obj_cnt SHALL be loaded with sram_q, the new label SHALL be obj_cnt+1, and obj_cnt SHALL be incremented.
REQ-018 On a lookup miss with obj_cnt==MAX_OBJ, overflow SHALL be set and the pixel left unchanged.
REQ-019 The block SHALL enter WR only when the new label differs from sram_q; WR SHALL drive sram_a=addr, sram_d=new label and sram_wen=0 for exactly one cycle.
REQ-020 After CMP or WR, addr SHALL increment; if addr was IMG_PIX-1, the FSM SHALL go to DONE instead, with no wrap of addr.
REQ-021 A scan SHALL take 2 cycles per unchanged pixel and 3 cycles per rewritten pixel.
REQ-022 Accepting start SHALL clear addr, obj_cnt, overflow, done and every table valid bit in the same cycle.
REQ-023 Start while in RD, CMP or WR SHALL be ignored.
REQ-024 sram_wen SHALL be 1 in every state except WR.
REQ-025 Labels SHALL be assigned in raster order of first appearance; a second pass over an already-compacted image SHALL produce no writes.

Reset
REQ-026 While reset is high, the block SHALL hold state=IDLE, addr=0, sram_a=0, sram_d=0, sram_wen=1, done=0, obj_cnt=0, overflow=0 and all table valid bits=0.
REQ-027 Reset asserted mid-scan SHALL abort immediately, leaving SRAM partially remapped; no write SHALL occur after the reset edge.

Configuration
REQ-028 With macro LABEL_COMPACTOR_AREA_EN defined, the block SHALL add input area_sel[3:0] and output area[10:0], and SHALL keep one 11-bit pixel counter per table entry, incremented in CMP on a hit or allocate and cleared on start or reset.
REQ-029 With LABEL_COMPACTOR_AREA_EN defined, area SHALL combinationally show the counter for new label area_sel, and SHALL be 0 when area_sel is 0 or greater than obj_cnt.
REQ-030 Without LABEL_COMPACTOR_AREA_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-031 The state enum, MAX_OBJ, IMG_PIX and the address width (10) SHALL be placed in shared package label_compactor_pkg.
REQ-032 The lookup table and its compare/allocate logic SHALL be sub-module label_cam (inputs key, alloc, clear; outputs hit, idx).

Verification
REQ-033 All-zero SRAM, then start -> zero writes, done high after exactly 2048 cycles, obj_cnt=0.
REQ-034 Pixels 0x00..0x03 = 0x37 and pixel 0x3FF = 0x12 -> pixels 0..3 become 0x01 and pixel 0x3FF becomes 0x02; obj_cnt=2; 5 writes in total.
REQ-035 Sixteen distinct labels 0x10..0x1F at addresses 0..15 -> addresses 0..14 become 1..15, address 15 stays 0x1F, overflow=1, obj_cnt=15.
REQ-036 A second start after REQ-034 -> no sram_wen=0 cycle during the scan, and identical obj_cnt.
REQ-037 Reset pulsed at addr 0x200 mid-scan -> outputs return to their reset values at once, and a following start rescans from address 0.
REQ-038 With LABEL_COMPACTOR_AREA_EN, after the REQ-034 image -> area_sel=1 gives area=4, area_sel=2 gives area=1, and area_sel=3 gives area=0.
